// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter width for NDIG digits; never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// DIGIT_W-bit ripple of single-bit full-adder cells; the one adder slice
// shared across all digits of the serial adder.
module fa_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[DIGIT_W];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+ci, DIGIT_W bits per clock, LSB first.
// Optional signed-overflow output enabled by defining OVERFLOW_DETECT_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic [31:0]        base;
  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_co;

  assign base  = 32'(cnt_q) * 32'(DIGIT_W);
  assign dig_a = a_q[base +: DIGIT_W];
  assign dig_b = b_q[base +: DIGIT_W];

  fa_digit #(.DIGIT_W(DIGIT_W)) u_fa_digit (
    .x   (dig_a),
    .y   (dig_b),
    .cin (carry_q),
    .sum (dig_s),
    .cout(dig_co)
  );

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d[base +: DIGIT_W] = dig_s;
        carry_d = dig_co;
        if (cnt_q == LAST) begin
          // acc_d already carries the final digit, so s sees the full sum.
          s_d     = acc_d;
          co_d    = dig_co;
`ifdef OVERFLOW_DETECT_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
`ifdef OVERFLOW_DETECT_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 8/4, 1/1)
// compared against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sel   = 0;   // 0: WIDTH8/DIGIT1, 1: WIDTH8/DIGIT4, 2: WIDTH1/DIGIT1

  logic       p1_iv = 0, p1_ir, p1_ci = 0, p1_ov, p1_or = 0, p1_co, p1_ovf;
  logic [7:0] p1_a = 0, p1_b = 0, p1_s;
  logic       p4_iv = 0, p4_ir, p4_ci = 0, p4_ov, p4_or = 0, p4_co, p4_ovf;
  logic [7:0] p4_a = 0, p4_b = 0, p4_s;
  logic       w1_iv = 0, w1_ir, w1_ci = 0, w1_ov, w1_or = 0, w1_co, w1_ovf;
  logic [0:0] w1_a = 0, w1_b = 0, w1_s;

  serial_adder #(.WIDTH(8), .DIGIT_W(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(p1_iv), .in_ready(p1_ir), .a(p1_a), .b(p1_b),
    .ci(p1_ci), .out_valid(p1_ov), .out_ready(p1_or), .s(p1_s), .co(p1_co)
`ifdef OVERFLOW_DETECT_EN
    , .ovf(p1_ovf)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT_W(4)) u_p4 (
    .clk(clk), .rst(rst), .in_valid(p4_iv), .in_ready(p4_ir), .a(p4_a), .b(p4_b),
    .ci(p4_ci), .out_valid(p4_ov), .out_ready(p4_or), .s(p4_s), .co(p4_co)
`ifdef OVERFLOW_DETECT_EN
    , .ovf(p4_ovf)
`endif
  );

  serial_adder #(.WIDTH(1), .DIGIT_W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_iv), .in_ready(w1_ir), .a(w1_a), .b(w1_b),
    .ci(w1_ci), .out_valid(w1_ov), .out_ready(w1_or), .s(w1_s), .co(w1_co)
`ifdef OVERFLOW_DETECT_EN
    , .ovf(w1_ovf)
`endif
  );

`ifndef OVERFLOW_DETECT_EN
  assign p1_ovf = 1'b0;
  assign p4_ovf = 1'b0;
  assign w1_ovf = 1'b0;
`endif

  logic [7:0] m_s;
  logic       m_co, m_ov, m_ir, m_ovf;

  always_comb begin
    case (sel)
      1: begin m_ir = p4_ir; m_ov = p4_ov; m_s = p4_s; m_co = p4_co; m_ovf = p4_ovf; end
      2: begin m_ir = w1_ir; m_ov = w1_ov; m_s = {7'b0, w1_s}; m_co = w1_co; m_ovf = w1_ovf; end
      default: begin m_ir = p1_ir; m_ov = p1_ov; m_s = p1_s; m_co = p1_co; m_ovf = p1_ovf; end
    endcase
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (sel)
      1: begin p4_iv = v; p4_a = a; p4_b = b; p4_ci = c; end
      2: begin w1_iv = v; w1_a = a[0]; w1_b = b[0]; w1_ci = c; end
      default: begin p1_iv = v; p1_a = a; p1_b = b; p1_ci = c; end
    endcase
  endtask

  task automatic set_ready(input logic r);
    case (sel)
      1: p4_or = r;
      2: w1_or = r;
      default: p1_or = r;
    endcase
  endtask

  // One full transaction; lat = edges from handshake to out_valid (100 = timed out).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] so, output logic coo, output logic ovfo,
                        output int lat);
    int w = 0;
    @(negedge clk);
    while (!m_ir && w < 100) begin @(negedge clk); w++; end
    drive(1'b1, a, b, c);
    @(posedge clk); #1;
    drive(1'b0, a, b, c);
    lat = 0;
    while (!m_ov && lat < 100) begin @(posedge clk); #1; lat++; end
    so = m_s; coo = m_co; ovfo = m_ovf;
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
  endtask

  task automatic check_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] so;
    logic       coo, ovfo;
    int         lat, w, ndig, mask, half, tot, sa, sb, ssum;
    int         e_s, e_co, e_ovf;
    w    = (sel == 2) ? 1 : 8;
    ndig = (sel == 0) ? 8 : (sel == 1) ? 2 : 1;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    tot  = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    e_s  = tot & mask;
    e_co = tot >> w;
    sa   = ((int'(a) & mask) >= half) ? (int'(a) & mask) - (1 << w) : (int'(a) & mask);
    sb   = ((int'(b) & mask) >= half) ? (int'(b) & mask) - (1 << w) : (int'(b) & mask);
    ssum = sa + sb + int'(c);
    e_ovf = (ssum < -half || ssum > half - 1) ? 1 : 0;
    run_op(a, b, c, so, coo, ovfo, lat);
    tests++;
    if (int'(so) !== e_s) begin
      fails++; $display("FAIL %s sum a=%h b=%h ci=%0d: got %h want %h", nm, a, b, c, so, e_s);
    end
    tests++;
    if (int'(coo) !== e_co) begin
      fails++; $display("FAIL %s carry a=%h b=%h ci=%0d: got %0d want %0d", nm, a, b, c, coo, e_co);
    end
    tests++;
    if (lat !== ndig) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", nm, lat, ndig);
    end
`ifdef OVERFLOW_DETECT_EN
    tests++;
    if (int'(ovfo) !== e_ovf) begin
      fails++; $display("FAIL %s ovf a=%h b=%h ci=%0d: got %0d want %0d", nm, a, b, c, ovfo, e_ovf);
    end
`endif
  endtask

  task automatic test_reset;
    sel = 0;
    tests++;
    if (p1_ir !== 1'b1 || p1_ov !== 1'b0 || p1_s !== 8'h00 || p1_co !== 1'b0) begin
      fails++; $display("FAIL reset_state: ir=%b ov=%b s=%h co=%b want 1 0 00 0", p1_ir, p1_ov, p1_s, p1_co);
    end
    check_op("pre_reset_op", 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h55, 8'h66, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h55, 8'h66, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (p1_ir !== 1'b1 || p1_ov !== 1'b0 || p1_s !== 8'h00 || p1_co !== 1'b0 || p1_ovf !== 1'b0) begin
      fails++;
      $display("FAIL mid_op_reset: ir=%b ov=%b s=%h co=%b ovf=%b want 1 0 00 0 0", p1_ir, p1_ov, p1_s, p1_co, p1_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("post_reset_ovf", 8'h7F, 8'h01, 1'b0);
  endtask

  task automatic test_truth_table;
    sel = 2;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] av, bv;
      av = 8'(i >> 2) & 8'h01;
      bv = 8'(i >> 1) & 8'h01;
      check_op("fa_truth", av, bv, 1'(i));
    end
  endtask

  task automatic test_directed;
    sel = 0;
    check_op("w8d1_ff_plus_1", 8'hFF, 8'h01, 1'b0);
    sel = 1;
    check_op("w8d4_3c_5a_1", 8'h3C, 8'h5A, 1'b1);
    check_op("w8d4_ff_ff_1", 8'hFF, 8'hFF, 1'b1);
    sel = 0;
    check_op("w8d1_80_80_0", 8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      for (int i = 0; i < 15; i++)
        check_op("random", 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_backpressure;
    int w;
    sel = 0;
    @(negedge clk);
    drive(1'b1, 8'h12, 8'h34, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 8'hAA, 8'hAA, 1'b1);
    w = 0;
    while (!m_ov && w < 100) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      tests++;
      if (m_s !== 8'h47 || m_co !== 1'b0 || m_ir !== 1'b0 || m_ov !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold cyc%0d: s=%h co=%b ir=%b ov=%b want 47 0 0 1", i, m_s, m_co, m_ir, m_ov);
      end
    end
    @(negedge clk);
    drive(1'b1, 8'hC8, 8'h64, 1'b0);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    tests++;
    if (m_ov !== 1'b0 || m_ir !== 1'b1) begin
      fails++; $display("FAIL release_to_idle: ov=%b ir=%b want 0 1", m_ov, m_ir);
    end
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tests++;
    if (m_s !== 8'h47 || m_co !== 1'b0) begin
      fails++; $display("FAIL hold_during_add: s=%h co=%b want 47 0", m_s, m_co);
    end
    w = 0;
    while (!m_ov && w < 100) begin @(posedge clk); #1; w++; end
    tests++;
    if (w !== 8 || m_s !== 8'h2C || m_co !== 1'b1) begin
      fails++; $display("FAIL next_after_release: lat=%0d s=%h co=%b want 8 2c 1", w, m_s, m_co);
    end
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset_wait();
    test_reset;
    test_truth_table;
    test_directed;
    test_random;
    test_backpressure;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic test_reset_wait;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

endmodule
